jam_cost_arbiter: RTL and testbench
===================================

// Module: jam_cost_arbiter
// PURPOSE
//   Shares the single cost-ROM read port (W/J -> Cost) between two permutation-search
//   engines (engine 0, engine 1), each enumerating half of the assignment space.
//   Grants one whole permutation at a time, round-robin. Sequences the N row reads
//   W=0..N-1, J=perm[W] and accumulates the returned costs. Returns the total to the
//   granted engine with a one-cycle Done pulse. Engines never drive W/J directly.
// PARAMETERS
//   N        8   rows/columns per permutation
//   IDX_W    3   width of one row/column index (clog2 N)
//   COST_W   7   width of one Cost entry
//   SUM_W    10  accumulated sum width; N*(2^COST_W-1) must fit (8*127=1016)
//   ROM_LAT  1   cycles from W/J driven to Cost valid (>=1)
// PORTS
//   CLK    in   1            clock, all state on rising edge
//   RST    in   1            synchronous, active-high reset
//   Req0   in   1            engine 0 request; held with Perm0 until Ack0
//   Perm0  in   N*IDX_W      engine 0 permutation; J for row k = Perm0[k*IDX_W +: IDX_W]
//   Ack0   out  1            one-cycle pulse: Perm0 captured, grant to engine 0
//   Done0  out  1            one-cycle pulse: Sum0 valid
//   Sum0   out  SUM_W        total cost of last completed engine-0 permutation
//   Req1/Perm1/Ack1/Done1/Sum1   same for engine 1
//   W      out  IDX_W        ROM row address
//   J      out  IDX_W        ROM column address
//   RD     out  1            ROM read strobe, high while W/J valid
//   Cost   in   COST_W       ROM data, valid ROM_LAT cycles after its W/J
//   Busy   out  1            high in every state except IDLE
// BEHAVIOUR
//   Reset: state IDLE; Ack*, Done*, RD, Busy = 0; W = J = 0; Sum0 = Sum1 = 0;
//     accumulator and row counter 0; rr pointer = "last served engine 1"
//     (engine 0 wins first tie). Reset mid-operation aborts: no Done, no Sum update.
//   FSM: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
//   IDLE: Req sampled only here. Neither -> stay. One -> grant it. Both -> grant the
//     engine not last served; rr pointer updates on grant.
//     On grant: latch Perm, clear accumulator, row counter = 0, go ISSUE.
//   Timing, Req seen in IDLE in cycle c:
//     Ack high in cycle c+1 only (registered).
//     ISSUE occupies cycles c+1..c+N: RD=1, W=row counter, J=latched perm[W].
//     Cost for row k sampled and added at end of cycle c+1+k+ROM_LAT.
//     DRAIN: ROM_LAT cycles (c+N+1..c+N+ROM_LAT); RD=0, W=J=0.
//     RESP in cycle c+N+1+ROM_LAT: Done of granted engine high, its Sum updated same
//       cycle. N=8, ROM_LAT=1 -> Done at c+10; IDLE at c+11; earliest next Ack c+12.
//   Cost is accumulated only via a ROM_LAT-deep valid shift of RD, never from raw Cost.
//   Outside ISSUE: W=J=0, RD=0.
//   Sum0/Sum1 hold value until next Done of the same engine; other engine's Sum untouched.
//   Accumulator: zero-extend Cost to SUM_W; no overflow possible under parameter rule.
//   Engines drop Req in their Ack cycle. Req still high in the next IDLE is a new
//     request (with Perm resampled).
//   Req asserted while Busy: waits, not lost while held. Req dropped before grant:
//     request withdrawn, no Ack.
//   Perm not checked for duplicates/out-of-range; indices go to J unmodified.
// TESTING
//   1. ROM Cost=8*W+J, Req0 with identity perm at cycle c -> Ack0 at c+1, W/J=0/0..7/7
//      over c+1..c+8, Done0 at c+10, Sum0=252; Done1 never pulses, Sum1=0.
//   2. Req0 and Req1 both high out of reset at c -> Ack0 c+1, Done0 c+10,
//      Ack1 c+12, Done1 c+21.
//   3. Req0, Req1 held high (re-raised after each Ack) for 6 grants -> grants 0,1,0,1,0,1;
//      no engine served twice in a row.
//   4. All ROM entries 127, perm 7,6,5,4,3,2,1,0 -> Sum=1016, no wrap.
//   5. RST during ISSUE (row 4) -> next cycle IDLE, RD=W=J=0, no Done, Sum unchanged at 0;
//      new Req1 afterwards completes normally with correct sum.
//   6. ROM_LAT=3, ROM model delays 3 cycles, test 1 stimulus -> Done0 at c+12, Sum0=252.

Source files
------------

// File: rtl/jam_cost_arbiter_if.sv
// Bundle shared between the two permutation-search engines, the cost ROM and the arbiter.
// Engine side: Req*/Perm* in, Ack*/Done*/Sum* out.
// ROM side: W/J/RD out, Cost in.
// Busy is high whenever the arbiter is not idle.
// The master modport is the engines plus ROM; the slave modport is the arbiter.
interface jam_cost_arbiter_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned COST_W = 7,
  parameter int unsigned SUM_W  = 10
);
  logic                  Req0;
  logic [N*IDX_W-1:0]    Perm0;
  logic                  Ack0;
  logic                  Done0;
  logic [SUM_W-1:0]      Sum0;
  logic                  Req1;
  logic [N*IDX_W-1:0]    Perm1;
  logic                  Ack1;
  logic                  Done1;
  logic [SUM_W-1:0]      Sum1;
  logic [IDX_W-1:0]      W;
  logic [IDX_W-1:0]      J;
  logic                  RD;
  logic [COST_W-1:0]     Cost;
  logic                  Busy;

  modport master (
    output Req0, Perm0, Req1, Perm1, Cost,
    input  Ack0, Done0, Sum0, Ack1, Done1, Sum1, W, J, RD, Busy
  );

  modport slave (
    input  Req0, Perm0, Req1, Perm1, Cost,
    output Ack0, Done0, Sum0, Ack1, Done1, Sum1, W, J, RD, Busy
  );
endinterface

// File: rtl/jam_cost_arbiter.sv
// Shares one cost-ROM read port between two permutation-search engines.
// A whole permutation is granted at a time, round-robin on ties. The arbiter reads the
// N rows (W=row, J=perm[row]) and accumulates the returned costs. The total goes back
// to the granted engine with a one-cycle Done pulse.
// Ports:
//   CLK  - clock; all state changes on the rising edge
//   RST  - synchronous, active-high reset
//   bus  - engine request/response signals and ROM address/data (slave modport)
module jam_cost_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned COST_W  = 7,
  parameter int unsigned SUM_W   = 10,
  parameter int unsigned ROM_LAT = 1
) (
  input logic              CLK,
  input logic              RST,
  jam_cost_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StResp} state_e;

  localparam logic [IDX_W-1:0] LastRow = IDX_W'(N - 1);

  state_e                      state_q, state_d;
  logic                        rr_q, rr_d;    // last served engine
  logic                        gnt_q, gnt_d;  // engine owning the current permutation
  logic [N-1:0][IDX_W-1:0]     perm_q, perm_d;
  logic [IDX_W-1:0]            row_q, row_d;
  logic [SUM_W-1:0]            acc_q, acc_d;
  logic [SUM_W-1:0]            sum0_q, sum0_d;
  logic [SUM_W-1:0]            sum1_q, sum1_d;
  logic [ROM_LAT-1:0]          vld_q, vld_d;  // RD delayed to line up with Cost
  logic                        ack0_q, ack0_d;
  logic                        ack1_q, ack1_d;
  logic                        rd;
  logic                        pick;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      rr_q    <= 1'b1;
      gnt_q   <= 1'b0;
      perm_q  <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      sum0_q  <= '0;
      sum1_q  <= '0;
      vld_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      perm_q  <= perm_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      sum0_q  <= sum0_d;
      sum1_q  <= sum1_d;
      vld_q   <= vld_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.Req0 || bus.Req1) state_d = StIssue;
      StIssue: if (row_q == LastRow) state_d = StDrain;
      // Leave once the final in-flight read is being accumulated this cycle.
      StDrain: if (vld_d == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: grant, row counter, valid shift and accumulation
  always_comb begin
    rr_d   = rr_q;
    gnt_d  = gnt_q;
    perm_d = perm_q;
    row_d  = row_q;
    acc_d  = acc_q;
    sum0_d = sum0_q;
    sum1_d = sum1_q;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    pick   = 1'b0;

    vld_d    = vld_q << 1;
    vld_d[0] = rd;

    if (vld_q[ROM_LAT-1]) acc_d = acc_q + SUM_W'(bus.Cost);

    unique case (state_q)
      StIdle: begin
        if (bus.Req0 || bus.Req1) begin
          // On a tie the engine not served last wins.
          pick   = (bus.Req0 && bus.Req1) ? ~rr_q : bus.Req1;
          gnt_d  = pick;
          rr_d   = pick;
          perm_d = pick ? bus.Perm1 : bus.Perm0;
          acc_d  = '0;
          row_d  = '0;
          ack0_d = ~pick;
          ack1_d = pick;
        end
      end
      StIssue: row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
      StDrain: begin
        // Register the total as RESP is entered so Sum is valid alongside Done.
        if (state_d == StResp) begin
          if (gnt_q) sum1_d = acc_d;
          else       sum0_d = acc_d;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    rd        = (state_q == StIssue);
    bus.RD    = rd;
    bus.W     = rd ? row_q : '0;
    bus.J     = rd ? perm_q[row_q] : '0;
    bus.Busy  = (state_q != StIdle);
    bus.Ack0  = ack0_q;
    bus.Ack1  = ack1_q;
    bus.Done0 = (state_q == StResp) && !gnt_q;
    bus.Done1 = (state_q == StResp) && gnt_q;
    bus.Sum0  = sum0_q;
    bus.Sum1  = sum1_q;
  end

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter. Instance a has ROM latency 1 and instance b has
// ROM latency 3. Each has its own ROM model: Cost = 8*W + J, or 127 for every entry.
module tb_jam_cost_arbiter;
  localparam int unsigned N      = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned COST_W = 7;
  localparam int unsigned SUM_W  = 10;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  jam_cost_arbiter_if #(.N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W)) ifa ();
  jam_cost_arbiter_if #(.N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W)) ifb ();

  jam_cost_arbiter #(
    .N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W), .ROM_LAT(1)
  ) dut_a (
    .CLK(CLK),
    .RST(RST),
    .bus(ifa.slave)
  );

  jam_cost_arbiter #(
    .N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W), .ROM_LAT(3)
  ) dut_b (
    .CLK(CLK),
    .RST(RST),
    .bus(ifb.slave)
  );

  logic rom_all_max = 1'b0;

  function automatic logic [COST_W-1:0] rom(input logic [IDX_W-1:0] w, input logic [IDX_W-1:0] j);
    if (rom_all_max) rom = 7'd127;
    else             rom = COST_W'(8 * int'(w) + int'(j));
  endfunction

  // ROM models: one register stage for a, three stages for b
  logic [COST_W-1:0] b_s1, b_s2;
  always @(posedge CLK) begin
    ifa.Cost <= rom(ifa.W, ifa.J);
    b_s1     <= rom(ifb.W, ifb.J);
    b_s2     <= b_s1;
    ifb.Cost <= b_s2;
  end

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single request on dut_a: Ack next cycle, Done 10 cycles after the request cycle.
  task automatic serve(input bit e, input logic [N*IDX_W-1:0] p, input logic [31:0] exp_sum,
                       input string tag);
    if (e) begin ifa.Req1 = 1'b1; ifa.Perm1 = p; end
    else   begin ifa.Req0 = 1'b1; ifa.Perm0 = p; end
    tick;
    check({tag, "_ack"}, e ? ifa.Ack1 : ifa.Ack0, 1);
    ifa.Req0 = 1'b0;
    ifa.Req1 = 1'b0;
    repeat (9) tick;
    check({tag, "_done"}, e ? ifa.Done1 : ifa.Done0, 1);
    check({tag, "_sum"}, e ? 32'(ifa.Sum1) : 32'(ifa.Sum0), exp_sum);
    tick;
    check({tag, "_idle"}, ifa.Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [N*IDX_W-1:0] p_id, p_rev, p_five;
  int   ngrant;
  int   g;
  logic seen;

  initial begin
    RST = 1'b1;
    ifa.Req0 = 1'b0; ifa.Req1 = 1'b0; ifa.Perm0 = '0; ifa.Perm1 = '0;
    ifb.Req0 = 1'b0; ifb.Req1 = 1'b0; ifb.Perm0 = '0; ifb.Perm1 = '0;
    for (int k = 0; k < N; k++) begin
      p_id[k*IDX_W +: IDX_W]   = IDX_W'(k);
      p_rev[k*IDX_W +: IDX_W]  = IDX_W'(N - 1 - k);
      p_five[k*IDX_W +: IDX_W] = IDX_W'(5);
    end

    // Reset state
    repeat (3) tick;
    check("rst_busy", ifa.Busy, 0);
    check("rst_rd", ifa.RD, 0);
    check("rst_w", ifa.W, 0);
    check("rst_j", ifa.J, 0);
    check("rst_ack0", ifa.Ack0, 0);
    check("rst_done0", ifa.Done0, 0);
    check("rst_sum0", ifa.Sum0, 0);
    check("rst_sum1", ifa.Sum1, 0);
    RST = 1'b0;
    tick;

    // Test 1: identity permutation on engine 0, sum 9*28 = 252
    ifa.Req0 = 1'b1; ifa.Perm0 = p_id;
    tick;
    check("t1_ack0", ifa.Ack0, 1);
    check("t1_ack1", ifa.Ack1, 0);
    check("t1_busy", ifa.Busy, 1);
    ifa.Req0 = 1'b0;
    for (int k = 0; k < N; k++) begin
      check("t1_rd", ifa.RD, 1);
      check("t1_w", ifa.W, k);
      check("t1_j", ifa.J, k);
      if (k == 1) check("t1_ack_pulse", ifa.Ack0, 0);
      tick;
    end
    check("t1_drain_rd", ifa.RD, 0);
    check("t1_drain_w", ifa.W, 0);
    check("t1_drain_done", ifa.Done0, 0);
    tick;
    check("t1_done0", ifa.Done0, 1);
    check("t1_sum0", ifa.Sum0, 252);
    check("t1_done1", ifa.Done1, 0);
    check("t1_sum1", ifa.Sum1, 0);
    tick;
    check("t1_done_pulse", ifa.Done0, 0);
    check("t1_idle", ifa.Busy, 0);
    check("t1_sum0_hold", ifa.Sum0, 252);

    // Test 2: both request out of reset; engine 1 uses J=5 everywhere -> 224+40 = 264
    RST = 1'b1;
    tick;
    RST = 1'b0;
    ifa.Req0 = 1'b1; ifa.Perm0 = p_id;
    ifa.Req1 = 1'b1; ifa.Perm1 = p_five;
    tick;
    check("t2_ack0", ifa.Ack0, 1);
    check("t2_ack1_early", ifa.Ack1, 0);
    ifa.Req0 = 1'b0;
    repeat (9) tick;
    check("t2_done0", ifa.Done0, 1);
    check("t2_sum0", ifa.Sum0, 252);
    check("t2_done1_early", ifa.Done1, 0);
    tick;
    check("t2_ack1_c11", ifa.Ack1, 0);
    check("t2_idle_c11", ifa.Busy, 0);
    tick;
    check("t2_ack1", ifa.Ack1, 1);
    check("t2_ack0_c12", ifa.Ack0, 0);
    ifa.Req1 = 1'b0;
    repeat (8) tick;
    check("t2_done1_c20", ifa.Done1, 0);
    tick;
    check("t2_done1", ifa.Done1, 1);
    check("t2_sum1", ifa.Sum1, 264);
    check("t2_sum0_kept", ifa.Sum0, 252);
    tick;

    // Test 3: both held and re-raised; grants must alternate starting with engine 0
    ngrant = 0;
    ifa.Req0 = 1'b1; ifa.Perm0 = p_id;
    ifa.Req1 = 1'b1; ifa.Perm1 = p_id;
    for (int cyc = 0; cyc < 200 && ngrant < 6; cyc++) begin
      tick;
      if (ifa.Ack0 || ifa.Ack1) begin
        g = ifa.Ack1 ? 1 : 0;
        check("t3_single_ack", ifa.Ack0 & ifa.Ack1, 0);
        check("t3_grant", g, ngrant % 2);
        ngrant++;
        if (g == 1) ifa.Req1 = 1'b0;
        else        ifa.Req0 = 1'b0;
      end else begin
        ifa.Req0 = 1'b1;
        ifa.Req1 = 1'b1;
      end
    end
    ifa.Req0 = 1'b0;
    ifa.Req1 = 1'b0;
    check("t3_count", ngrant, 6);
    for (int cyc = 0; cyc < 20 && ifa.Busy; cyc++) tick;
    check("t3_idle", ifa.Busy, 0);
    tick;

    // Test 4: all entries 127 -> 8*127 = 1016 without wrap
    rom_all_max = 1'b1;
    tick;
    serve(1'b0, p_rev, 1016, "t4");
    rom_all_max = 1'b0;
    tick;

    // Test 5: reset while row 4 is issued aborts the permutation
    ifa.Req0 = 1'b1; ifa.Perm0 = p_id;
    tick;
    check("t5_ack0", ifa.Ack0, 1);
    ifa.Req0 = 1'b0;
    repeat (4) tick;
    check("t5_row4", ifa.W, 4);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("t5_busy", ifa.Busy, 0);
    check("t5_rd", ifa.RD, 0);
    check("t5_w", ifa.W, 0);
    check("t5_j", ifa.J, 0);
    check("t5_sum0", ifa.Sum0, 0);
    seen = ifa.Done0 | ifa.Done1;
    for (int i = 0; i < 8; i++) begin
      tick;
      seen = seen | ifa.Done0 | ifa.Done1;
    end
    check("t5_no_done", seen, 0);
    serve(1'b1, p_five, 264, "t5b");
    check("t5_sum0_after", ifa.Sum0, 0);

    // Test 6: ROM latency 3 -> Done at c+12
    ifb.Req0 = 1'b1; ifb.Perm0 = p_id;
    tick;
    check("t6_ack0", ifb.Ack0, 1);
    check("t6_w0", ifb.W, 0);
    ifb.Req0 = 1'b0;
    repeat (8) tick;
    check("t6_drain_rd", ifb.RD, 0);
    repeat (2) tick;
    check("t6_done_c11", ifb.Done0, 0);
    tick;
    check("t6_done0", ifb.Done0, 1);
    check("t6_sum0", ifb.Sum0, 252);
    tick;
    check("t6_idle", ifb.Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
